// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM state and latched memory command types for mem_arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef struct packed {
    logic        read;
    logic        write;
    logic [31:0] addr;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } mem_cmd_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester command/response and shared memory signals of mem_arbiter.
interface mem_arbiter_if;
  logic        req0_read, req0_write, req1_read, req1_write;
  logic [31:0] req0_addr, req1_addr, req0_wdata, req1_wdata;
  logic [3:0]  req0_wmask, req1_wmask;
  logic [31:0] req0_rdata, req1_rdata;
  logic        req0_resp, req1_resp;
  logic        mem_read, mem_write, mem_resp, error;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  modport slave (
    input  req0_read, req0_write, req0_addr, req0_wmask, req0_wdata,
    input  req1_read, req1_write, req1_addr, req1_wmask, req1_wdata,
    output req0_rdata, req0_resp, req1_rdata, req1_resp,
    output mem_read, mem_write, mem_addr, mem_wmask, mem_wdata,
    input  mem_rdata, mem_resp,
    output error
  );
  modport master (
    output req0_read, req0_write, req0_addr, req0_wmask, req0_wdata,
    output req1_read, req1_write, req1_addr, req1_wmask, req1_wdata,
    input  req0_rdata, req0_resp, req1_rdata, req1_resp,
    input  mem_read, mem_write, mem_addr, mem_wmask, mem_wdata,
    output mem_rdata, mem_resp,
    input  error
  );
endinterface

// File: rtl/mem_arb_grant.sv
// mem_arb_grant: picks one of two legal requests; MEM_ARB_RR_EN selects round-robin over fixed priority.
module mem_arb_grant (
  input  logic [1:0] req,
`ifdef MEM_ARB_RR_EN
  input  logic       ptr,
`endif
  output logic       valid,
  output logic       id
);
  assign valid = |req;
`ifdef MEM_ARB_RR_EN
  // ptr holds the last-served requester, so a tie goes to the other one
  assign id = &req ? ~ptr : req[1];
`else
  assign id = req[1];
`endif
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester shared-memory arbiter with IDLE/BUSY/DONE sequencing and hang timeout.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed priority with requester 1 first.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t          state;
  mem_cmd_t        cmd;
  mem_cmd_t        req_cmd [2];
  logic [CW-1:0]   cnt;
  logic [1:0]      resp, legal, bad;
  logic [1:0][31:0] rdata;
  logic            gnt_valid, gnt_id, cur, error, expired;
`ifdef MEM_ARB_RR_EN
  logic            ptr;
`endif
  assign req_cmd[0] = {bus.req0_read, bus.req0_write, bus.req0_addr, bus.req0_wmask, bus.req0_wdata};
  assign req_cmd[1] = {bus.req1_read, bus.req1_write, bus.req1_addr, bus.req1_wmask, bus.req1_wdata};
  assign bad        = {bus.req1_read & bus.req1_write, bus.req0_read & bus.req0_write};
  assign legal      = {bus.req1_read ^ bus.req1_write, bus.req0_read ^ bus.req0_write};
  assign expired    = cnt == CW'(TIMEOUT - 1);
  mem_arb_grant u_grant (
    .req   (legal),
`ifdef MEM_ARB_RR_EN
    .ptr   (ptr),
`endif
    .valid (gnt_valid),
    .id    (gnt_id)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cmd   <= '0;
      cnt   <= '0;
      cur   <= 1'b0;
      resp  <= '0;
      rdata <= '0;
      error <= 1'b0;
`ifdef MEM_ARB_RR_EN
      ptr   <= 1'b0;
`endif
    end else begin
      resp <= '0;
      case (state)
        IDLE: begin
          if (|bad) error <= 1'b1;
          if (gnt_valid) begin
            cmd   <= req_cmd[gnt_id];
            cur   <= gnt_id;
            cnt   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (bus.mem_resp || expired) begin
            cmd.read  <= 1'b0;
            cmd.write <= 1'b0;
            state     <= DONE;
`ifdef MEM_ARB_RR_EN
            ptr       <= cur;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
          // a hung transaction ends silently; only a real response pulses resp
          if (bus.mem_resp) begin
            resp[cur]  <= 1'b1;
            rdata[cur] <= bus.mem_rdata;
          end else if (expired) begin
            error <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.mem_read   = cmd.read;
  assign bus.mem_write  = cmd.write;
  assign bus.mem_addr   = cmd.addr;
  assign bus.mem_wmask  = cmd.wmask;
  assign bus.mem_wdata  = cmd.wdata;
  assign bus.req0_resp  = resp[0];
  assign bus.req1_resp  = resp[1];
  assign bus.req0_rdata = rdata[0];
  assign bus.req1_rdata = rdata[1];
  assign bus.error      = error;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a transaction-level model.
module tb_mem_arbiter;
  localparam int TO = 8;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  mem_arbiter_if bus();
  mem_arbiter #(.TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_chk = 0, n_pass = 0, cyc = 0, delay = 3, wcnt = 0, fall_t = 0;
  bit silent = 0, poke = 0, last = 0;
  logic [31:0] dev_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] exp_rdata [2] = '{32'h0, 32'h0};
  bit          act [2];
  logic        op_wr [2];
  logic [31:0] op_a [2], op_d [2];
  logic [3:0]  op_m [2];
  typedef struct { logic wr; logic [31:0] addr; logic [3:0] m; logic [31:0] d; int t; } cmd_rec_t;
  typedef struct { int id; logic [31:0] data; int t; } resp_rec_t;
  cmd_rec_t  cmds [$];
  resp_rec_t resps [$];
  logic pstb = 0, presp = 0, pwr = 0;
  logic [31:0] paddr = 0, pdat = 0;
  logic [3:0] pm = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] m);
    for (int i = 0; i < 4; i++) if (m[i]) old[8*i +: 8] = d[8*i +: 8];
    return old;
  endfunction
  function automatic logic [31:0] ref_rd(logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction
  // service order rule: a lone request goes first; a tie goes to 1 (fixed) or away from the last served (RR)
  function automatic int first(bit a0, bit a1, bit lst);
    return (a0 && a1) ? (RR ? int'(!lst) : 1) : (a1 ? 1 : 0);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // memory device: answers after `delay` strobe cycles, churns rdata otherwise
  always @(posedge clk) begin
    if (!rst_n) begin
      bus.mem_resp <= 1'b0;
      wcnt = 0;
    end else if (poke) begin
      bus.mem_resp  <= 1'b1;
      bus.mem_rdata <= 32'hBAD0BAD0;
    end else if (bus.mem_resp) begin
      bus.mem_resp  <= 1'b0;
      bus.mem_rdata <= $urandom;
      wcnt = 0;
    end else if ((bus.mem_read || bus.mem_write) && !silent) begin
      wcnt++;
      if (wcnt >= delay) begin
        bus.mem_resp <= 1'b1;
        if (bus.mem_write) begin
          dev_mem[bus.mem_addr] = merge(dev_mem.exists(bus.mem_addr) ? dev_mem[bus.mem_addr] : 32'h0,
                                        bus.mem_wdata, bus.mem_wmask);
          bus.mem_rdata <= 32'h0;
        end else begin
          bus.mem_rdata <= dev_mem.exists(bus.mem_addr) ? dev_mem[bus.mem_addr] : 32'h0;
        end
      end else begin
        bus.mem_rdata <= $urandom;
      end
    end else begin
      wcnt = 0;
      bus.mem_rdata <= $urandom;
    end
  end

  // bus monitor: logs issued commands and response pulses, checks strobe/response invariants
  always @(negedge clk) begin
    if (!rst_n) begin
      pstb  = 0;
      presp = 0;
    end else begin
      if (bus.mem_read || bus.mem_write) begin
        chk("mem_excl", bus.mem_read & bus.mem_write, 0);
        if (pstb) begin
          chk("stable_addr", bus.mem_addr, paddr);
          chk("stable_wdata", bus.mem_wdata, pdat);
          chk("stable_wr_mask", {bus.mem_write, bus.mem_wmask}, {pwr, pm});
        end else begin
          cmds.push_back('{bus.mem_write, bus.mem_addr, bus.mem_wmask, bus.mem_wdata, cyc});
        end
      end else if (pstb) begin
        fall_t = cyc;
      end
      if (bus.req0_resp || bus.req1_resp) begin
        chk("resp_excl", bus.req0_resp & bus.req1_resp, 0);
        chk("resp_pulse", presp, 0);
        resps.push_back('{bus.req1_resp ? 1 : 0, bus.req1_resp ? bus.req1_rdata : bus.req0_rdata, cyc});
      end
      pstb  = bus.mem_read | bus.mem_write;
      presp = bus.req0_resp | bus.req1_resp;
      {paddr, pdat, pwr, pm} = {bus.mem_addr, bus.mem_wdata, bus.mem_write, bus.mem_wmask};
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int id, input logic r, input logic w, input logic [31:0] a,
                       input logic [3:0] m, input logic [31:0] d);
    if (id == 0) {bus.req0_read, bus.req0_write, bus.req0_addr, bus.req0_wmask, bus.req0_wdata} = {r, w, a, m, d};
    else         {bus.req1_read, bus.req1_write, bus.req1_addr, bus.req1_wmask, bus.req1_wdata} = {r, w, a, m, d};
  endtask

  task automatic set_op(input int id, input logic wr, input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
    act[id] = 1; op_wr[id] = wr; op_a[id] = a; op_m[id] = m; op_d[id] = d;
  endtask

  // each requester holds its command until its own resp pulse
  task automatic run(input int max);
    int n = 0;
    while ((bus.req0_read | bus.req0_write | bus.req1_read | bus.req1_write) && n < max) begin
      step();
      n++;
      if (bus.req0_resp) drive(0, 0, 0, 0, 0, 0);
      if (bus.req1_resp) drive(1, 0, 0, 0, 0, 0);
    end
    chk("run_bound", n < max, 1);
    step(3);
  endtask

  task automatic do_round();
    int order [$];
    int f, s, id;
    cmds.delete();
    resps.delete();
    for (int i = 0; i < 2; i++) if (act[i]) drive(i, !op_wr[i], op_wr[i], op_a[i], op_m[i], op_d[i]);
    s = cyc;
    run(300);
    f = first(act[0], act[1], last);
    order.push_back(f);
    if (act[0] && act[1]) order.push_back(1 - f);
    chk("n_cmds", cmds.size(), order.size());
    chk("n_resps", resps.size(), order.size());
    if (cmds.size() == order.size() && resps.size() == order.size()) begin
      chk("grant_lat", cmds[0].t - s, 1);
      foreach (order[k]) begin
        id = order[k];
        chk("cmd_wr", cmds[k].wr, op_wr[id]);
        chk("cmd_addr", cmds[k].addr, op_a[id]);
        if (op_wr[id]) begin
          chk("cmd_wmask", cmds[k].m, op_m[id]);
          chk("cmd_wdata", cmds[k].d, op_d[id]);
          ref_mem[op_a[id]] = merge(ref_rd(op_a[id]), op_d[id], op_m[id]);
          exp_rdata[id] = 32'h0;
        end else begin
          exp_rdata[id] = ref_rd(op_a[id]);
        end
        chk("resp_id", resps[k].id, id);
        chk("resp_data", resps[k].data, exp_rdata[id]);
        chk("resp_lat", resps[k].t - cmds[k].t, delay + 1);
        if (k > 0) chk("idle_gap", cmds[k].t - resps[k-1].t, 2);
        last = id[0];
      end
    end
    chk("rdata0_hold", bus.req0_rdata, exp_rdata[0]);
    chk("rdata1_hold", bus.req1_rdata, exp_rdata[1]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    dev_mem[32'h40]  = 32'h12345678; ref_mem[32'h40]  = 32'h12345678;
    dev_mem[32'h200] = 32'h11223344; ref_mem[32'h200] = 32'h11223344;
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    step(3);
    chk("rst_strobe", {bus.mem_read, bus.mem_write}, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_wdata_mask", {bus.mem_wdata, bus.mem_wmask}, 0);
    chk("rst_resp", {bus.req0_resp, bus.req1_resp}, 0);
    chk("rst_rdata", bus.req0_rdata | bus.req1_rdata, 0);
    chk("rst_err", bus.error, 0);
    rst_n = 1'b1;
    step(2);

    // single read, memory delay 3
    act = '{0, 0}; delay = 3;
    set_op(0, 0, 32'h40, 4'h0, 32'h0);
    do_round();

    // simultaneous read (req0) and masked write (req1), then read back
    act = '{0, 0};
    set_op(0, 0, 32'h100, 4'h0, 32'h0);
    set_op(1, 1, 32'h200, 4'b0011, 32'hDEADBEEF);
    do_round();
    act = '{0, 0};
    set_op(0, 0, 32'h200, 4'h0, 32'h0);
    do_round();
    chk("rb_low_half", bus.req0_rdata[15:0], 16'hBEEF);

    // illegal read+write on req1 alongside a legal req0 read
    cmds.delete(); resps.delete();
    drive(1, 1, 1, 32'h300, 4'hF, 32'h1);
    drive(0, 1, 0, 32'h40, 0, 0);
    chk("err_pre", bus.error, 0);
    step();
    chk("err_set", bus.error, 1);
    drive(1, 0, 0, 0, 0, 0);
    run(100);
    chk("ill_ncmd", cmds.size(), 1);
    if (cmds.size() == 1) chk("ill_cmd", {cmds[0].wr, cmds[0].addr}, {1'b0, 32'h40});
    chk("ill_nresp", resps.size(), 1);
    if (resps.size() == 1) chk("ill_resp", {resps[0].id[0], resps[0].data}, {1'b0, 32'h12345678});
    exp_rdata[0] = 32'h12345678;
    last = 0;

    // spurious mem_resp while idle
    resps.delete();
    poke = 1; step(); poke = 0; step(3);
    chk("spur_noresp", resps.size(), 0);
    chk("spur_rdata0", bus.req0_rdata, exp_rdata[0]);
    chk("spur_rdata1", bus.req1_rdata, exp_rdata[1]);
    chk("err_sticky", bus.error, 1);

    // reset in the second busy cycle abandons the transaction
    delay = 4; cmds.delete(); resps.delete();
    drive(0, 1, 0, 32'h40, 0, 0);
    step(2);
    chk("pre_rst_busy", bus.mem_read, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_strobe", {bus.mem_read, bus.mem_write}, 0);
    chk("arst_addr", bus.mem_addr, 0);
    chk("arst_err", bus.error, 0);
    chk("arst_rdata0", bus.req0_rdata, 0);
    drive(0, 0, 0, 0, 0, 0);
    step(2);
    rst_n = 1'b1;
    step(8);
    chk("rst_noresp", resps.size(), 0);
    exp_rdata = '{32'h0, 32'h0};
    last = 0;
    act = '{0, 0};
    set_op(0, 0, 32'h200, 4'h0, 32'h0);
    do_round();

    // randomized rounds
    for (int r = 0; r < 30; r++) begin
      act = '{0, 0};
      while (!act[0] && !act[1]) begin
        act[0] = 1'($urandom_range(0, 1));
        act[1] = 1'($urandom_range(0, 1));
      end
      for (int i = 0; i < 2; i++) begin
        op_wr[i] = 1'($urandom_range(0, 1));
        op_a[i]  = 32'h1000 + 4 * $urandom_range(0, 3);
        op_m[i]  = 4'($urandom);
        op_d[i]  = $urandom;
      end
      delay = $urandom_range(1, 4);
      do_round();
    end
    chk("rand_no_err", bus.error, 0);

    // memory never answers
    silent = 1; cmds.delete(); resps.delete();
    drive(0, 1, 0, 32'h80, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    n = 0;
    while (bus.mem_read && n < 50) begin
      step();
      n++;
    end
    chk("to_bound", n < 50, 1);
    step(3);
    chk("to_ncmd", cmds.size(), 1);
    if (cmds.size() == 1) chk("to_len", fall_t - cmds[0].t, TO);
    chk("to_err", bus.error, 1);
    chk("to_noresp", resps.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64: cycles without mem_resp before a transaction is flagged as hung.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-004 SHALL have ports reqN_read and reqN_write, input, 1 each (N=0,1): requester N read/write strobes.
REQ-005 SHALL have ports reqN_addr, input, 32; reqN_wmask, input, 4; reqN_wdata, input, 32: requester N command fields.
REQ-006 SHALL have ports reqN_rdata, output, 32, and reqN_resp, output, 1: requester N read data and one-cycle completion pulse.
REQ-007 SHALL have ports mem_read, mem_write, output, 1; mem_addr, output, 32; mem_wmask, output, 4; mem_wdata, output, 32: shared memory command.
REQ-008 SHALL have ports mem_rdata, input, 32, and mem_resp, input, 1: shared memory response.
REQ-009 SHALL have port error, output, 1: sticky protocol/timeout error flag.

Function
REQ-010 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-011 IDLE: on any pending request, SHALL grant one requester and register its read, write, addr, wmask and wdata; next state BUSY.
REQ-012 BUSY: SHALL drive mem_* only from the registered command; addr, wmask, wdata and the strobe stay constant until mem_resp.
REQ-013 SHALL never assert mem_read and mem_write together.
REQ-014 BUSY with mem_resp=1: SHALL register mem_rdata into granted reqN_rdata, pulse granted reqN_resp for exactly one cycle, and go to DONE.
REQ-015 DONE: SHALL hold mem_read=mem_write=0 for exactly one cycle, then go to IDLE; this gives a mandatory idle gap between memory transactions.
REQ-016 Minimum latency: request seen in IDLE at edge k drives mem_* after edge k; reqN_resp is high in the cycle after the edge that samples mem_resp.
REQ-017 Requesters SHALL hold their request stable until reqN_resp; the arbiter ignores input changes while that requester is granted.
REQ-018 Arbitration without ARB_RR_EN: fixed priority, requester 1 (data) over requester 0 (fetch).
REQ-019 reqN_read=reqN_write=1 sampled in IDLE: SHALL set error, grant nobody from N that cycle, and still serve the other requester.
REQ-020 BUSY for TIMEOUT consecutive cycles without mem_resp: SHALL set error, drop the strobe, and go to DONE without pulsing reqN_resp.
REQ-021 mem_resp in IDLE or DONE SHALL be ignored.
REQ-022 The ungranted reqN_resp SHALL stay 0; reqN_rdata SHALL hold its last value between responses.
REQ-023 Timeout counter width SHALL be $clog2(TIMEOUT+1); the counter clears on every grant.

Reset
REQ-024 On rst_n low, asynchronously: state=IDLE, mem_read=mem_write=0, mem_addr=mem_wdata=0, mem_wmask=0, reqN_resp=0, reqN_rdata=0, error=0, round-robin pointer=0, counter=0.
REQ-025 Reset mid-transaction SHALL abandon it; no reqN_resp pulse follows reset release.
REQ-026 error SHALL clear only on reset.

Configuration
REQ-027 With macro MEM_ARB_RR_EN defined: SHALL use round-robin arbitration; the pointer toggles to the other requester after every completed grant; simultaneous requests go to the pointed-to requester.
REQ-028 Without MEM_ARB_RR_EN: SHALL use fixed priority per REQ-018, with no pointer register.

Structure
REQ-029 Shared package mem_arb_pkg SHALL hold the FSM state enum (IDLE, BUSY, DONE) and the mem_cmd_t struct (read, write, addr, wmask, wdata).
REQ-030 Sub-module mem_arb_grant SHALL contain the combinational grant logic (priority/round-robin); FSM and registers stay in mem_arbiter.

Verification
REQ-031 req0_read addr 0x0000_0040 alone, memory DELAY=3 -> mem_read held with constant addr until mem_resp; req0_resp pulses once with rdata; one idle cycle follows.
REQ-032 req0_read 0x100 and req1_write 0x200 (wmask 4'b0011, wdata 0xDEADBEEF) issued the same cycle, fixed priority -> write served first, then read; reading back 0x200 returns low halfword 0xBEEF.
REQ-033 With MEM_ARB_RR_EN, both requesters continuously requesting for 6 transactions -> grants alternate 1,0,1,0,1,0 with no gaps other than DONE.
REQ-034 req1_read=req1_write=1 -> error=1; no mem strobe issued for requester 1; a concurrent req0 request still completes.
REQ-035 Memory never responds, TIMEOUT=8 -> strobe drops after 8 BUSY cycles, error=1, no reqN_resp.
REQ-036 rst_n asserted in the second BUSY cycle -> all outputs 0 immediately; no resp pulse after release; a new request then completes normally.
